// File: rtl/dsp48a1_result_drain.sv
// dsp48a1_result_drain: follows each operand set through the DSP48A1 pipeline,
// captures {CARRYOUT, P} on the cycle the result emerges, and buffers it in a
// small ready/valid FIFO. Issue is credit-gated so a result always has a slot.
module dsp48a1_result_drain #(
  parameter int width_reg = 48,
  parameter int LATENCY   = 3,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clkE,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [width_reg-1:0]     P,
  input  logic                     CARRYOUT,
  output logic [width_reg:0]       out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = width_reg + 1;

  // Tracker, counters and FIFO state
  logic [LATENCY-1:0] trk_q, trk_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic               valid_q, valid_d;
  logic [DW-1:0]      mem_q [DEPTH];
  logic [DW-1:0]      mem_d [DEPTH];

  logic               accept;
  logic               capture;
  logic               pop;
  logic [CW:0]        credit_sum;
  logic [LATENCY:0]   trk_ext;

  // Credits: results already buffered plus results still in the slice must
  // fit in the FIFO. Both terms are registers; clkE low means the slice
  // cannot take an operand set, so no credit is offered.
  always_comb begin
    credit_sum  = {1'b0, count_q} + {1'b0, inflight_q};
    issue_ready = clkE & (credit_sum < (CW+1)'(DEPTH));
    accept      = issue_valid & issue_ready;
    capture     = clkE & trk_q[LATENCY-1];
    pop         = valid_q & out_ready;
  end

  // Valid tracker shifts in lockstep with the slice registers
  always_comb begin
    trk_ext = {trk_q, accept};
    trk_d   = trk_q;
    if (clkE) trk_d = trk_ext[LATENCY-1:0];
  end

  // In-flight counter: issues entering minus results leaving the slice
  always_comb begin
    inflight_d = inflight_q;
    case ({accept, capture})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // FIFO pointers, occupancy and storage
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (capture) begin
      mem_d[wptr_q] = {CARRYOUT, P};
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop) rptr_d = rptr_q + PW'(1);
    case ({capture, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
  end

  // State registers; reset also discards whatever is still in the slice
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_q      <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      valid_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      trk_q      <= trk_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      valid_q    <= valid_d;
      mem_q      <= mem_d;
    end
  end

  // Head entry is a plain register read; nothing depends on out_ready
  always_comb begin
    out_data  = mem_q[rptr_q];
    out_valid = valid_q;
    count     = count_q;
  end

  // The credit scheme must make a push into a full FIFO impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(capture && !pop && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_dsp48a1_result_drain.sv
// Directed bench for dsp48a1_result_drain (width 48, LATENCY 3, DEPTH 4).
module tb_dsp48a1_result_drain;

  logic        clk = 1'b0;
  logic        rst, clkE, issue_valid, issue_ready;
  logic [47:0] P;
  logic        CARRYOUT;
  logic [48:0] out_data;
  logic        out_valid, out_ready;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  dsp48a1_result_drain #(.width_reg(48), .LATENCY(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clkE(clkE),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .P(P), .CARRYOUT(CARRYOUT),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ce, iv, ordy;
    logic [48:0] din;
    logic        eir, eov, cd;
    logic [48:0] edata;
    logic [2:0]  ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic ce, logic iv, logic [48:0] din,
                             logic ordy, logic eir, logic eov, logic cd,
                             logic [48:0] edata, logic [2:0] ecnt);
    vec_t t;
    t.rst = r; t.ce = ce; t.iv = iv; t.din = din; t.ordy = ordy;
    t.eir = eir; t.eov = eov; t.cd = cd; t.edata = edata; t.ecnt = ecnt;
    return t;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [48:0] tag(int k);
    return {k[0], 32'hC0DE_0000, k[15:0]};
  endfunction

  localparam logic [48:0] R1 = 49'h1_0000_1234_5678;
  localparam logic [48:0] A1 = 49'h1_AAAA_0000_0001;
  localparam logic [48:0] A2 = 49'h0_AAAA_0000_0002;
  localparam logic [48:0] A3 = 49'h1_AAAA_0000_0003;
  localparam logic [48:0] B0 = 49'h0_BBBB_0000_0000;
  localparam logic [48:0] B1 = 49'h1_BBBB_0000_0001;
  localparam logic [48:0] B2 = 49'h0_BBBB_0000_0002;

  initial begin
    logic [48:0] prev;
    logic        stall;
    logic [48:0] sb[$];

    // reset state, clkE low: no credit offered
    tbl.push_back(v(0,0,1,0,0,            0,0,1,49'h0,0));
    // single issue, result at t+3, visible at t+4, popped
    tbl.push_back(v(0,1,1,0,0,            1,0,1,49'h0,0));
    tbl.push_back(v(0,1,0,0,0,            1,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,            1,0,0,0,0));
    tbl.push_back(v(0,1,0,R1,0,           1,0,0,0,0));
    tbl.push_back(v(0,1,0,0,1,            1,1,1,R1,1));
    tbl.push_back(v(0,1,0,0,0,            1,0,0,0,0));
    // fill: out_ready low, continuous issue, only 4 credits
    tbl.push_back(v(0,1,1,0,0,            1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,            1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,            1,0,0,0,0));
    tbl.push_back(v(0,1,1,49'd1,0,        1,0,0,0,0));
    tbl.push_back(v(0,1,1,49'd2,0,        0,1,1,49'd1,1));
    tbl.push_back(v(0,1,1,49'd3,0,        0,1,1,49'd1,2));
    tbl.push_back(v(0,1,1,49'd4,0,        0,1,1,49'd1,3));
    tbl.push_back(v(0,1,1,49'h99,1,       0,1,1,49'd1,4));
    tbl.push_back(v(0,1,0,0,1,            1,1,1,49'd2,3));
    tbl.push_back(v(0,1,0,0,1,            1,1,1,49'd3,2));
    tbl.push_back(v(0,1,0,0,1,            1,1,1,49'd4,1));
    tbl.push_back(v(0,1,0,0,0,            1,0,0,0,0));
    // clkE low for 2 cycles mid-flight: capture delayed by 2
    tbl.push_back(v(0,1,1,0,0,            1,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,            1,0,0,0,0));
    tbl.push_back(v(0,0,1,0,0,            0,0,0,0,0));
    tbl.push_back(v(0,0,0,49'h1_FFFF_FFFF_FFFF,0, 0,0,0,0,0));
    tbl.push_back(v(0,1,0,49'h1_1111,0,   1,0,0,0,0));
    tbl.push_back(v(0,1,0,49'h0ABC,0,     1,0,0,0,0));
    tbl.push_back(v(0,1,0,0,1,            1,1,1,49'h0ABC,1));
    tbl.push_back(v(0,1,0,0,0,            1,0,0,0,0));
    // push and pop together at count=2
    tbl.push_back(v(0,1,1,0,0,            1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,            1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,            1,0,0,0,0));
    tbl.push_back(v(0,1,0,A1,0,           1,0,0,0,0));
    tbl.push_back(v(0,1,0,A2,0,           1,1,1,A1,1));
    tbl.push_back(v(0,1,0,A3,1,           1,1,1,A1,2));
    tbl.push_back(v(0,1,0,0,1,            1,1,1,A2,2));
    tbl.push_back(v(0,1,0,0,1,            1,1,1,A3,1));
    tbl.push_back(v(0,1,0,0,0,            1,0,0,0,0));
    // reset with 1 buffered and 2 in flight
    tbl.push_back(v(0,1,1,0,0,            1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,            1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,            1,0,0,0,0));
    tbl.push_back(v(0,1,0,B0,0,           1,0,0,0,0));
    tbl.push_back(v(1,1,0,B1,0,           1,1,1,B0,1));
    tbl.push_back(v(0,1,0,B2,0,           1,0,1,49'h0,0));
    tbl.push_back(v(0,1,0,0,0,            1,0,1,49'h0,0));
    tbl.push_back(v(0,1,0,0,1,            1,0,0,0,0));

    rst = 1'b1; clkE = 1'b1; issue_valid = 1'b0; out_ready = 1'b0;
    P = '0; CARRYOUT = 1'b0;
    repeat (3) @(posedge clk);

    foreach (tbl[i]) begin
      if (i != 0) @(posedge clk);
      #1;
      rst = tbl[i].rst; clkE = tbl[i].ce; issue_valid = tbl[i].iv;
      out_ready = tbl[i].ordy; {CARRYOUT, P} = tbl[i].din;
      #1;
      chk($sformatf("row%0d issue_ready", i), 64'(issue_ready), 64'(tbl[i].eir));
      chk($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(tbl[i].eov));
      chk($sformatf("row%0d count", i), 64'(count), 64'(tbl[i].ecnt));
      if (tbl[i].cd)
        chk($sformatf("row%0d out_data", i), 64'(out_data), 64'(tbl[i].edata));
    end

    // streaming with out_ready toggling, then drain
    stall = 1'b0; prev = '0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      rst = 1'b0; clkE = 1'b1;
      issue_valid = (k < 40);
      out_ready = (k >= 40) ? 1'b1 : ~k[0];
      {CARRYOUT, P} = tag(k);
      #1;
      if (stall) begin
        chk("stall out_valid", 64'(out_valid), 64'(1));
        chk("stall out_data", 64'(out_data), 64'(prev));
      end
      chk("count range", 64'(count <= 3'd4), 64'(1));
      if (issue_valid && issue_ready) sb.push_back(tag(k + 3));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL stream extra: got %h expected no entry", out_data);
        end else begin
          chk("stream data", 64'(out_data), 64'(sb.pop_front()));
        end
      end
      stall = out_valid && !out_ready;
      prev  = out_data;
    end
    chk("stream leftover", 64'(sb.size()), 64'(0));
    chk("stream final count", 64'(count), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
